fat32_cluster_lba: RTL and testbench

FAT32_CLUSTER_LBA -- requirements
Module: fat32_cluster_lba

---
 rtl/fat32_cluster_lba.sv | 243 ++++++++++++++++++++++++
 tb/tb_fat32_cluster_lba.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fat32_cluster_lba.sv
// fat32_cluster_lba
// Turns a FAT32 cluster number into the run of sector LBAs that make up the
// cluster. The formula is data_start + (cluster - 2) * sectors_per_cluster,
// and the block emits one LBA per handshake.
//
// Build option:
//   CLUSTER_LBA_SHIFT_ADD_EN defined   : the multiply is an 8-cycle shift-add,
//                                        so any sectors_per_cluster in 1..255
//                                        is accepted.
//   CLUSTER_LBA_SHIFT_ADD_EN undefined : the multiply is a single-cycle left
//                                        shift, so only power-of-two
//                                        sectors_per_cluster values are
//                                        accepted.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for a request; req_ready high once out of reset
// S_CHECK | validate the captured cluster number and sectors_per_cluster
// S_MUL   | form the base LBA (shift, or shift-add iterations)
// S_EMIT  | present base+idx with lba_valid until the last sector is taken
// S_ERR   | one-cycle err pulse for a rejected request

module fat32_cluster_lba #(
    parameter int LBA_WIDTH    = 32,
    parameter int CLUSTER_BITS = 28
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [LBA_WIDTH-1:0] data_start_lba,
    input  logic [7:0]           sectors_per_cluster,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [31:0]          req_cluster,
    input  logic                 abort,
    output logic                 lba_valid,
    input  logic                 lba_ready,
    output logic [LBA_WIDTH-1:0] lba,
    output logic                 lba_last,
    output logic                 busy,
    output logic                 err
);

    // The cluster is held at least LBA_WIDTH wide so that the offset can be
    // truncated to the LBA width (the result wraps modulo 2^LBA_WIDTH).
    localparam int XW = (CLUSTER_BITS > LBA_WIDTH) ? CLUSTER_BITS : LBA_WIDTH;
    localparam logic [XW-1:0] CLUS_MIN = XW'(2);
    localparam logic [XW-1:0] CLUS_END = XW'(32'h0FFF_FFF7);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_MUL,
        S_EMIT,
        S_ERR
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [XW-1:0]        clus_q;
    logic [LBA_WIDTH-1:0] ds_q;
    logic [7:0]           spc_q;
    logic [7:0]           idx;
    logic                 init_done;

    logic                 accept;
    logic                 beat;
    logic [XW-1:0]        off_full;
    logic [LBA_WIDTH-1:0] off_lba;
    logic                 req_bad;
    logic                 mul_fin;
    logic [LBA_WIDTH-1:0] base_val;

`ifdef CLUSTER_LBA_SHIFT_ADD_EN
    logic [LBA_WIDTH-1:0] acc;
    logic [LBA_WIDTH-1:0] acc_nxt;
    logic [LBA_WIDTH-1:0] mcand;
    logic [7:0]           mplier;
    logic [2:0]           mul_cnt;
`else
    logic [2:0]           sh;
    logic                 spc_pow2;
`endif

    assign accept   = req_valid && req_ready;
    assign beat     = lba_valid && lba_ready;
    assign off_full = clus_q - CLUS_MIN;
    assign off_lba  = off_full[LBA_WIDTH-1:0];

`ifdef CLUSTER_LBA_SHIFT_ADD_EN
    // Shift-add step: add the shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        acc_nxt  = acc + (mplier[0] ? mcand : '0);
        mul_fin  = (mul_cnt == 3'd0);
        base_val = acc_nxt;
        req_bad  = (clus_q < CLUS_MIN) || (clus_q >= CLUS_END) ||
                   (spc_q == 8'd0);
    end
`else
    // Shift path: spc is a power of two, so the multiply is a shift by log2(spc).
    always_comb begin
        sh = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (spc_q[i]) begin
                sh = 3'(i);
            end
        end
        spc_pow2 = ((spc_q & (spc_q - 8'd1)) == 8'd0);
        mul_fin  = 1'b1;
        base_val = ds_q + (off_lba << sh);
        req_bad  = (clus_q < CLUS_MIN) || (clus_q >= CLUS_END) ||
                   (spc_q == 8'd0) || !spc_pow2;
    end
`endif

    // State register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort wins over every other transition.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (req_bad) begin
                    state_nxt = S_ERR;
                end else begin
                    state_nxt = S_MUL;
                end
            end
            S_MUL: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (mul_fin) begin
                    state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (abort || (beat && lba_last)) begin
                    state_nxt = S_IDLE;
                end
            end
            S_ERR: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State-decoded outputs. req_ready waits for the first edge after reset.
    always_comb begin
        busy      = (state != S_IDLE);
        req_ready = (state == S_IDLE) && !abort && init_done;
        err       = (state == S_ERR) && !abort;
    end

    // Datapath: request capture, base computation and the per-sector walk.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            init_done <= 1'b0;
            clus_q    <= '0;
            ds_q      <= '0;
            spc_q     <= '0;
            idx       <= '0;
            lba       <= '0;
            lba_valid <= 1'b0;
            lba_last  <= 1'b0;
`ifdef CLUSTER_LBA_SHIFT_ADD_EN
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            mul_cnt   <= '0;
`endif
        end else begin
            init_done <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        clus_q <= XW'(req_cluster[CLUSTER_BITS-1:0]);
                        ds_q   <= data_start_lba;
                        spc_q  <= sectors_per_cluster;
                    end
                end
                S_CHECK: begin
`ifdef CLUSTER_LBA_SHIFT_ADD_EN
                    acc     <= ds_q;
                    mcand   <= off_lba;
                    mplier  <= spc_q;
                    mul_cnt <= 3'd7;
`endif
                end
                S_MUL: begin
`ifdef CLUSTER_LBA_SHIFT_ADD_EN
                    acc     <= acc_nxt;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    mul_cnt <= mul_cnt - 3'd1;
`endif
                    if (state_nxt == S_EMIT) begin
                        lba       <= base_val;
                        lba_valid <= 1'b1;
                        lba_last  <= (spc_q == 8'd1);
                        idx       <= '0;
                    end
                end
                S_EMIT: begin
                    if (abort) begin
                        lba_valid <= 1'b0;
                        lba_last  <= 1'b0;
                        idx       <= '0;
                    end else if (beat) begin
                        if (lba_last) begin
                            lba_valid <= 1'b0;
                            lba_last  <= 1'b0;
                            idx       <= '0;
                        end else begin
                            idx      <= idx + 8'd1;
                            lba      <= lba + 1'b1;
                            lba_last <= ((idx + 8'd1) == (spc_q - 8'd1));
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fat32_cluster_lba.sv
// Bench for fat32_cluster_lba: a table of directed requests with
// hand-computed LBA runs, plus stall/abort and mid-burst reset sequences.
module tb_fat32_cluster_lba;

`ifdef CLUSTER_LBA_SHIFT_ADD_EN
    localparam int LAT     = 10;
    localparam bit NP2_ERR = 1'b0;
`else
    localparam int LAT     = 3;
    localparam bit NP2_ERR = 1'b1;
`endif
    localparam int BOUND = 600;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [31:0] data_start_lba = '0;
    logic [7:0]  sectors_per_cluster = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_cluster = '0;
    logic        abort = 1'b0;
    logic        lba_valid;
    logic        lba_ready = 1'b0;
    logic [31:0] lba;
    logic        lba_last;
    logic        busy;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] ds;
        logic [7:0]  spc;
        logic [31:0] cl;
        bit          exp_err;
        logic [31:0] exp_lba;
        int          exp_beats;
    } vec_t;

    vec_t vecs[11];

    fat32_cluster_lba #(.LBA_WIDTH(32), .CLUSTER_BITS(28)) dut (
        .sys_clk             (sys_clk),
        .sys_rst             (sys_rst),
        .data_start_lba      (data_start_lba),
        .sectors_per_cluster (sectors_per_cluster),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_cluster         (req_cluster),
        .abort               (abort),
        .lba_valid           (lba_valid),
        .lba_ready           (lba_ready),
        .lba                 (lba),
        .lba_last            (lba_last),
        .busy                (busy),
        .err                 (err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    // Present a request at a negedge, let it be taken, then scramble the inputs.
    task automatic start_req(input logic [31:0] ds, input logic [7:0] spc, input logic [31:0] cl);
        @(negedge sys_clk);
        data_start_lba      = ds;
        sectors_per_cluster = spc;
        req_cluster         = cl;
        req_valid           = 1'b1;
        #1;
        chk("req_ready_idle", req_ready, 1);
        @(posedge sys_clk);
        @(negedge sys_clk);
        req_valid           = 1'b0;
        data_start_lba      = $urandom;
        sectors_per_cluster = 8'($urandom);
        req_cluster         = $urandom;
    endtask

    task automatic run_vec(input vec_t v);
        int  edges;
        int  beats;
        int  errs;
        int  first_lat;
        bit  done;
        lba_ready = 1'b1;
        start_req(v.ds, v.spc, v.cl);
        edges = 1; beats = 0; errs = 0; first_lat = -1; done = 1'b0;
        while (!done && edges < BOUND) begin
            if (err) errs++;
            if (lba_valid) begin
                if (beats == 0) first_lat = edges;
                chk("lba", lba, v.exp_lba + 32'(beats));
                chk("lba_last", lba_last, (beats == v.exp_beats - 1));
                beats++;
                if (lba_last) done = 1'b1;
                step();
                edges++;
            end else if (errs > 0 && !busy) begin
                done = 1'b1;
            end else begin
                step();
                edges++;
            end
        end
        chk("no_timeout", (edges < BOUND), 1);
        chk("err_pulses", errs, v.exp_err ? 1 : 0);
        chk("beats", beats, v.exp_err ? 0 : v.exp_beats);
        if (!v.exp_err) chk("first_latency", first_lat, LAT);
        chk("idle_busy", busy, 0);
        chk("idle_valid", lba_valid, 0);
        chk("idle_ready", req_ready, 1);
    endtask

    initial begin
        vecs[0]  = '{32'h2000,     8'd8,   32'h0000_0002, 1'b0,    32'h2000,     8};
        vecs[1]  = '{32'h2000,     8'd8,   32'hF000_0005, 1'b0,    32'h2018,     8};
        vecs[2]  = '{32'h2000,     8'd8,   32'h0000_0001, 1'b1,    32'h0,        0};
        vecs[3]  = '{32'h2000,     8'd8,   32'h0FFF_FFF7, 1'b1,    32'h0,        0};
        vecs[4]  = '{32'h2000,     8'd0,   32'h0000_0002, 1'b1,    32'h0,        0};
        vecs[5]  = '{32'h2000,     8'd6,   32'h0000_0003, NP2_ERR, 32'h2006,     6};
        vecs[6]  = '{32'h0100,     8'd1,   32'h0000_000A, 1'b0,    32'h0108,     1};
        vecs[7]  = '{32'h0100,     8'd2,   32'h0FFF_FFF6, 1'b0,    32'h2000_00E8, 2};
        vecs[8]  = '{32'hFFFF_FFFE, 8'd4,  32'h0000_0002, 1'b0,    32'hFFFF_FFFE, 4};
        vecs[9]  = '{32'h0000,     8'd3,   32'h0000_0004, NP2_ERR, 32'h0006,     3};
        vecs[10] = '{32'h2000,     8'd8,   32'h1000_0001, 1'b1,    32'h0,        0};

        // Reset state.
        repeat (2) @(negedge sys_clk);
        chk("rst_lba", lba, 0);
        chk("rst_valid", lba_valid, 0);
        chk("rst_last", lba_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", req_ready, 0);
        sys_rst = 1'b0;
        #1;
        chk("rel_ready_before_edge", req_ready, 0);
        step();
        chk("rel_ready_after_edge", req_ready, 1);

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i]);
        end

        // Stall on beat 2, then abort, then abort beating a simultaneous request.
        begin
            int n;
            lba_ready = 1'b1;
            start_req(32'h2000, 8'd8, 32'h2);
            n = 0;
            while (!(lba_valid && lba == 32'h2002) && n < 50) begin
                step();
                n++;
            end
            chk("stall_reach", (n < 50), 1);
            lba_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
                step();
                chk("stall_lba", lba, 32'h2002);
                chk("stall_valid", lba_valid, 1);
                chk("stall_last", lba_last, 0);
            end
            abort = 1'b1;
            step();
            chk("abort_valid", lba_valid, 0);
            chk("abort_busy", busy, 0);
            chk("abort_err", err, 0);
            data_start_lba      = 32'h2000;
            sectors_per_cluster = 8'd8;
            req_cluster         = 32'h2;
            req_valid           = 1'b1;
            #1;
            chk("abort_blocks_ready", req_ready, 0);
            step();
            chk("abort_req_ignored", busy, 0);
            req_valid = 1'b0;
            abort     = 1'b0;
            #1;
            chk("post_abort_ready", req_ready, 1);
        end

        // Reset pulsed mid-burst, then a fresh request starts from scratch.
        begin
            int n;
            lba_ready = 1'b1;
            start_req(32'h2000, 8'd8, 32'h2);
            n = 0;
            while (!(lba_valid && lba == 32'h2003) && n < 50) begin
                step();
                n++;
            end
            chk("mid_reach", (n < 50), 1);
            sys_rst = 1'b1;
            #1;
            chk("midrst_lba", lba, 0);
            chk("midrst_valid", lba_valid, 0);
            chk("midrst_last", lba_last, 0);
            chk("midrst_busy", busy, 0);
            chk("midrst_err", err, 0);
            chk("midrst_ready", req_ready, 0);
            step();
            step();
            sys_rst = 1'b0;
            #1;
            chk("midrel_ready_before_edge", req_ready, 0);
            step();
            chk("midrel_ready", req_ready, 1);
            run_vec(vecs[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
